sseg_display_driver: RTL and testbench

- Consumes a 16-bit value from the OTTER memory-mapped display register and drives the board's 4-digit seven-segment display.
- Output ports are the board-level CATHODES/ANODES pins of the top-level wrapper.
- Two display modes:
  - Hex: direct nibble display.
  - Decimal: sequential binary-to-BCD conversion, with overflow indication and leading-zero blanking.

---
 rtl/sseg_pkg.sv | 38 +++
 rtl/bin2bcd_seq.sv | 46 ++++
 rtl/sseg_display_driver.sv | 153 +++++++++++++++
 tb/tb_sseg_display_driver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants, types and helpers for the seven-segment display driver
package sseg_pkg;

    // Active-low segment patterns, index = nibble value, bit 7 (dp) held off
    localparam logic [7:0] SEG_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Only segment g lit: shown on every digit when the decimal value exceeds 9999
    localparam logic [7:0] DASH    = 8'hBF;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam int BIN_W = 16;
    localparam int BCD_W = 20;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 16-bit binary to 5-digit BCD converter, one shift per clock
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] bcd_adj;
    logic [3:0]       shift_cnt;
    logic             active;

    assign bcd_adj = dabble_adjust(bcd_sr);

    // done flags the edge that performs the 16th shift, so bcd is final the cycle after
    assign done = active && (shift_cnt == 4'd15);
    assign bcd  = bcd_sr;

    // Capture on start, then shift the combined {bcd, bin} register left once per edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_sr    <= '0;
            bcd_sr    <= '0;
            shift_cnt <= '0;
            active    <= 1'b0;
        end else if (start) begin
            bin_sr    <= bin;
            bcd_sr    <= '0;
            shift_cnt <= '0;
            active    <= 1'b1;
        end else if (active) begin
            {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
            shift_cnt        <= shift_cnt + 4'd1;
            if (shift_cnt == 4'd15) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sseg_display_driver.sv
// rtl/sseg_display_driver.sv - 4-digit seven-segment driver with hex and decimal display modes
module sseg_display_driver
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        HEX_MODE,
    input  logic        DATA_VALID,
    output logic        BUSY,
    output logic [3:0]  ANODES,
    output logic [7:0]  CATHODES
);

    localparam int             DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t           state;
    state_t           state_nx;
    logic             start_conv;
    logic             load_hex;
    logic             load_bcd;

    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    logic [15:0]      disp_digits;
    logic             disp_ovf;

    logic [DIV_W-1:0] div_cnt;
    digit_idx_t       digit_idx;

    logic [3:0]       digit_blank;
    logic [3:0]       cur_nibble;
    logic [3:0]       anodes_nx;
    logic [7:0]       cathodes_nx;

    bin2bcd_seq u_bin2bcd (
        .CLK   (CLK),
        .RST   (RST),
        .start (start_conv),
        .bin   (DATA),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Load-control state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // New loads are only accepted in IDLE; anything arriving mid-conversion is dropped
    always_comb begin
        state_nx   = state;
        start_conv = 1'b0;
        load_hex   = 1'b0;
        load_bcd   = 1'b0;
        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    if (HEX_MODE) begin
                        load_hex = 1'b1;
                    end else begin
                        start_conv = 1'b1;
                        state_nx   = CONVERT;
                    end
                end
            end
            CONVERT: begin
                if (conv_done) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                load_bcd = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign BUSY = (state != IDLE);

    // Display register: hex nibbles immediately, decimal digits only once conversion ends
    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_digits <= '0;
            disp_ovf    <= 1'b0;
        end else if (load_hex) begin
            disp_digits <= DATA;
            disp_ovf    <= 1'b0;
        end else if (load_bcd) begin
            disp_digits <= conv_bcd[15:0];
            disp_ovf    <= (conv_bcd[19:16] != 4'd0);
        end
    end

    // Scan divider steps the active digit once every SCAN_DIV cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        digit_blank    = 4'b0000;
        digit_blank[3] = BLANK_LZ && !disp_ovf && (disp_digits[15:12] == 4'd0);
        digit_blank[2] = digit_blank[3] && (disp_digits[11:8] == 4'd0);
        digit_blank[1] = digit_blank[2] && (disp_digits[7:4] == 4'd0);
    end

    assign cur_nibble = disp_digits[digit_idx*4 +: 4];

    // Next pin values for the currently selected digit
    always_comb begin
        anodes_nx   = ~(4'b0001 << digit_idx);
        cathodes_nx = SEG_CODES[cur_nibble];
        if (disp_ovf) begin
            cathodes_nx = DASH;
        end else if (digit_blank[digit_idx]) begin
            anodes_nx   = AN_OFF;
            cathodes_nx = SEG_OFF;
        end
    end

    // Registered pins keep the board outputs glitch-free
    always_ff @(posedge CLK) begin
        if (RST) begin
            ANODES   <= AN_OFF;
            CATHODES <= SEG_OFF;
        end else begin
            ANODES   <= anodes_nx;
            CATHODES <= cathodes_nx;
        end
    end

endmodule

// File: tb/tb_sseg_display_driver.sv
// tb/tb_sseg_display_driver.sv - self-checking bench for sseg_display_driver with a value-level model
module tb_sseg_display_driver;

    localparam int SDIV = 4;

    logic        CLK;
    logic        RST;
    logic [15:0] DATA;
    logic        HEX_MODE;
    logic        DATA_VALID;
    logic        busy1, busy0;
    logic [3:0]  an1, an0;
    logic [7:0]  ca1, ca0;

    int n_cmp;
    int n_bad;
    int cyc;

    // Model of what the display register should be holding
    int m_val;
    bit m_hex;

    sseg_display_driver #(.SCAN_DIV(SDIV), .BLANK_LZ(1'b1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA       (DATA),
        .HEX_MODE   (HEX_MODE),
        .DATA_VALID (DATA_VALID),
        .BUSY       (busy1),
        .ANODES     (an1),
        .CATHODES   (ca1)
    );

    sseg_display_driver #(.SCAN_DIV(SDIV), .BLANK_LZ(1'b0)) dut_nb (
        .CLK        (CLK),
        .RST        (RST),
        .DATA       (DATA),
        .HEX_MODE   (HEX_MODE),
        .DATA_VALID (DATA_VALID),
        .BUSY       (busy0),
        .ANODES     (an0),
        .CATHODES   (ca0)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edges since reset was last released; the lit digit is a plain function of this count
    always @(posedge CLK) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
            12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // Expected {ANODES, CATHODES} when digit idx of value v is being shown
    function automatic logic [11:0] expect_out(input int v, input bit hex, input bit blz, input int idx);
        int base;
        int p;
        int hi;
        logic [3:0] an;
        base = hex ? 16 : 10;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * base;
        hi = v / p;
        an = ~(4'b0001 << idx);
        if (!hex && v >= 10000) return {an, 8'hBF};
        if (blz && idx > 0 && hi == 0) return {4'hF, 8'hFF};
        return {an, seg_of(hi % base)};
    endfunction

    function automatic int scan_idx(input int c);
        return ((c - 1) / SDIV) % 4;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        DATA = '0;
        HEX_MODE = 1'b0;
        DATA_VALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (an1 !== 4'hF || ca1 !== 8'hFF || busy1 !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_blz an=%h ca=%h busy=%b required an=f ca=ff busy=0", an1, ca1, busy1);
            end
            n_cmp++;
            if (an0 !== 4'hF || ca0 !== 8'hFF || busy0 !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_nb an=%h ca=%h busy=%b required an=f ca=ff busy=0", an0, ca0, busy0);
            end
        end
        RST = 1'b0;
        m_val = 0;
        m_hex = 1'b0;
    endtask

    // One full scan of both instances against the model contents
    task automatic test_scan_contents(input string tag);
        logic [11:0] e1, e0;
        int idx;
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 4 * SDIV; k++) begin
            idx = scan_idx(cyc);
            e1 = expect_out(m_val, m_hex, 1'b1, idx);
            e0 = expect_out(m_val, m_hex, 1'b0, idx);
            n_cmp++;
            if ({an1, ca1} !== e1) begin
                n_bad++;
                $display("FAIL scan_%s val=%0d hex=%0b digit=%0d got an=%h ca=%h required an=%h ca=%h",
                         tag, m_val, m_hex, idx, an1, ca1, e1[11:8], e1[7:0]);
            end
            n_cmp++;
            if ({an0, ca0} !== e0) begin
                n_bad++;
                $display("FAIL scan_nb_%s val=%0d hex=%0b digit=%0d got an=%h ca=%h required an=%h ca=%h",
                         tag, m_val, m_hex, idx, an0, ca0, e0[11:8], e0[7:0]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_hex_load(input int v);
        @(negedge CLK);
        DATA = v[15:0];
        HEX_MODE = 1'b1;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        DATA = 16'($urandom);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
                n_bad++;
                $display("FAIL hex_busy got %b/%b required 0", busy1, busy0);
            end
            @(negedge CLK);
        end
        m_val = v;
        m_hex = 1'b1;
    endtask

    // Decimal load: BUSY for 17 cycles, old contents on the pins throughout, optional ignored strobe
    task automatic test_decimal_load(input int v, input int inject_at, input string tag);
        logic [11:0] e1;
        int idx;
        @(negedge CLK);
        DATA = v[15:0];
        HEX_MODE = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        DATA = 16'($urandom);
        for (int k = 0; k < 17; k++) begin
            n_cmp++;
            if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
                n_bad++;
                $display("FAIL busy_%s cycle=%0d got %b/%b required 1", tag, k + 1, busy1, busy0);
            end
            idx = scan_idx(cyc);
            e1 = expect_out(m_val, m_hex, 1'b1, idx);
            n_cmp++;
            if ({an1, ca1} !== e1) begin
                n_bad++;
                $display("FAIL hold_%s cycle=%0d got an=%h ca=%h required an=%h ca=%h",
                         tag, k + 1, an1, ca1, e1[11:8], e1[7:0]);
            end
            if (k == inject_at) begin
                DATA = 16'd5;
                HEX_MODE = 1'($urandom_range(0, 1));
                DATA_VALID = 1'b1;
            end else begin
                DATA_VALID = 1'b0;
                HEX_MODE = 1'b0;
            end
            @(negedge CLK);
        end
        n_cmp++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_end_%s got %b/%b required 0", tag, busy1, busy0);
        end
        m_val = v;
        m_hex = 1'b0;
    endtask

    task automatic test_reset_mid_conversion();
        @(negedge CLK);
        DATA = 16'd42;
        HEX_MODE = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (busy1 !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_busy cycle=%0d got %b required 1", k + 1, busy1);
            end
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b0 || an1 !== 4'hF || ca1 !== 8'hFF) begin
            n_bad++;
            $display("FAIL abort_reset busy=%b an=%h ca=%h required busy=0 an=f ca=ff", busy1, an1, ca1);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_idle cycle=%0d got %b/%b required 0", k, busy1, busy0);
            end
        end
        m_val = 0;
        m_hex = 1'b0;
    endtask

    // Non-blanking instance: anodes walk E,D,B,7,E with SDIV samples per digit
    task automatic test_scan_wrap();
        logic [3:0] seq [5];
        int waited;
        seq[0] = 4'hE; seq[1] = 4'hD; seq[2] = 4'hB; seq[3] = 4'h7; seq[4] = 4'hE;
        waited = 0;
        @(negedge CLK);
        while (((cyc - 1) % (4 * SDIV)) != 0 && waited < 4 * SDIV + 2) begin
            @(negedge CLK);
            waited++;
        end
        n_cmp++;
        if (((cyc - 1) % (4 * SDIV)) != 0) begin
            n_bad++;
            $display("FAIL wrap_align cycle=%0d not reached within %0d cycles", cyc, waited);
        end
        for (int k = 0; k < 4 * SDIV + 1; k++) begin
            n_cmp++;
            if (an0 !== seq[k / SDIV]) begin
                n_bad++;
                $display("FAIL wrap_seq sample=%0d got %h required %h", k, an0, seq[k / SDIV]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_random_load(input int iter);
        int v;
        if ($urandom_range(0, 1) == 1) begin
            v = int'($urandom_range(0, 65535));
            test_hex_load(v);
        end else begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 65535));
            else if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 99));
            else v = int'($urandom_range(0, 9999));
            test_decimal_load(v, -1, $sformatf("rand%0d", iter));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_scan_contents("reset");
        test_hex_load(16'hA0F1);
        test_scan_contents("hex_a0f1");
        test_decimal_load(1234, -1, "d1234");
        test_scan_contents("d1234");
        test_decimal_load(10000, -1, "d10000");
        test_scan_contents("d10000");
        test_decimal_load(65535, -1, "d65535");
        test_scan_contents("d65535");
        test_decimal_load(9999, -1, "d9999");
        test_scan_contents("d9999");
        test_hex_load(16'h0000);
        test_scan_contents("hex_zero");
        test_decimal_load(42, 4, "ignore");
        test_scan_contents("ignore");
        test_reset_mid_conversion();
        test_scan_contents("abort");
        test_scan_wrap();
        for (int i = 0; i < 10; i++) begin
            test_random_load(i);
            test_scan_contents($sformatf("rand%0d", i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
